rff_share_arbiter: RTL and testbench

RFF_SHARE_ARBITER -- requirements
Module: rff_share_arbiter

---
 rtl/rff_share_arbiter.sv | 153 +++++++++++++++
 tb/tb_rff_share_arbiter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/rff_share_arbiter.sv
// rff_share_arbiter: round-robin arbiter that gives N requesters write access
// to one shared W-bit register. Each grant cycle commits the grantee's data.
//
// Ports:
//   clk    - rising-edge clock
//   reset  - asynchronous, active-low reset
//   req    - [N-1:0] per-requester write request
//   wdata  - [N*W-1:0] requester i data in bits [i*W+W-1 : i*W]
//   lock   - [N-1:0] per-requester grant hold (only with RFF_ARB_LOCK_EN)
//   gnt    - [N-1:0] registered one-hot grant
//   q      - [W-1:0] shared register contents
//   busy   - high while the FSM is in GRANT
//   wcnt   - [7:0] count of committed writes, wraps 255 -> 0
//
// Optional feature macro: RFF_ARB_LOCK_EN. It adds the lock port and lets a
// grantee hold the register for up to 8 consecutive cycles.

module rff_share_arbiter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  input  logic [N*W-1:0] wdata,
`ifdef RFF_ARB_LOCK_EN
  input  logic [N-1:0]   lock,
`endif
  output logic [N-1:0]   gnt,
  output logic [W-1:0]   q,
  output logic           busy,
  output logic [7:0]     wcnt
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t         state, state_nxt;
  logic [IW-1:0]  ptr, ptr_nxt;
  logic [IW-1:0]  gidx, gidx_nxt;
  logic [N-1:0]   gnt_nxt;
  logic           busy_nxt;
  logic           commit;
  logic           stay;
  logic           sel_found;
  logic [IW-1:0]  sel_idx;
  logic [IW-1:0]  ptr_inc;
  logic [W-1:0]   wsel;
`ifdef RFF_ARB_LOCK_EN
  logic [2:0]     lock_cnt, lock_cnt_nxt;
`endif

  // Round-robin search: first set req bit at or after ptr, modulo N.
  always_comb begin
    int j;
    sel_found = 1'b0;
    sel_idx   = '0;
    j         = 0;
    for (int k = 0; k < int'(N); k++) begin
      j = (int'(ptr) + k) % int'(N);
      if (!sel_found && req[j]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(j);
      end
    end
  end

  assign ptr_inc = (gidx == IW'(N - 1)) ? '0 : gidx + IW'(1);
  assign wsel    = wdata[int'(gidx)*int'(W) +: W];

  // Hold the grant only while the grantee asks for it and the burst is < 8.
  always_comb begin
`ifdef RFF_ARB_LOCK_EN
    stay = lock[gidx] && (lock_cnt < 3'd7);
`else
    stay = 1'b0;
`endif
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    gnt_nxt   = gnt;
    commit    = 1'b0;
`ifdef RFF_ARB_LOCK_EN
    lock_cnt_nxt = lock_cnt;
`endif
    case (state)
      IDLE: begin
        gnt_nxt = '0;
        if (sel_found) begin
          state_nxt        = GRANT;
          gidx_nxt         = sel_idx;
          gnt_nxt[sel_idx] = 1'b1;
        end
      end
      GRANT: begin
        // Every GRANT cycle commits, whether or not req is still held.
        commit = 1'b1;
        if (stay) begin
`ifdef RFF_ARB_LOCK_EN
          lock_cnt_nxt = lock_cnt + 3'd1;
`endif
        end else begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = ptr_inc;
`ifdef RFF_ARB_LOCK_EN
          lock_cnt_nxt = 3'd0;
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
      end
    endcase
    busy_nxt = (state_nxt == GRANT);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= '0;
      gidx  <= '0;
      gnt   <= '0;
      busy  <= 1'b0;
      q     <= '0;
      wcnt  <= 8'd0;
`ifdef RFF_ARB_LOCK_EN
      lock_cnt <= 3'd0;
`endif
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      gidx  <= gidx_nxt;
      gnt   <= gnt_nxt;
      busy  <= busy_nxt;
      if (commit) begin
        q    <= wsel;
        wcnt <= wcnt + 8'd1;
      end
`ifdef RFF_ARB_LOCK_EN
      lock_cnt <= lock_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rff_share_arbiter.sv
// Directed self-checking bench for rff_share_arbiter (N=4, W=8).
module tb_rff_share_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned W = 8;

  logic           clk;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] wdata;
`ifdef RFF_ARB_LOCK_EN
  logic [N-1:0]   lock;
`endif
  logic [N-1:0]   gnt;
  logic [W-1:0]   q;
  logic           busy;
  logic [7:0]     wcnt;

  int total = 0;
  int bad   = 0;

  rff_share_arbiter #(.N(N), .W(W)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .wdata (wdata),
`ifdef RFF_ARB_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .q     (q),
    .busy  (busy),
    .wcnt  (wcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse ending on a falling edge, away from the active edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    req   = '0;
    wdata = '0;
`ifdef RFF_ARB_LOCK_EN
    lock  = '0;
`endif
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_q", 32'(q), 32'h0);
    check("rst_wcnt", 32'(wcnt), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Single write from requester 0.
    req   = 4'b0001;
    wdata = {8'h00, 8'h00, 8'h00, 8'hA5};
    step();
    check("single_gnt", 32'(gnt), 32'h1);
    check("single_busy", 32'(busy), 32'h1);
    check("single_wcnt0", 32'(wcnt), 32'h0);
    req = '0;
    step();
    check("single_q", 32'(q), 32'hA5);
    check("single_wcnt", 32'(wcnt), 32'h1);
    check("single_gnt_off", 32'(gnt), 32'h0);
    check("single_busy_off", 32'(busy), 32'h0);

    // All four requesting: round robin from ptr 0.
    do_reset();
    req   = 4'b1111;
    wdata = {8'h44, 8'h33, 8'h22, 8'h11};
    step(); check("rr_g0", 32'(gnt), 32'h1);
    step(); check("rr_q0", 32'(q), 32'h11); check("rr_idle0", 32'(gnt), 32'h0);
    step(); check("rr_g1", 32'(gnt), 32'h2);
    step(); check("rr_q1", 32'(q), 32'h22);
    step(); check("rr_g2", 32'(gnt), 32'h4);
    step(); check("rr_q2", 32'(q), 32'h33);
    step(); check("rr_g3", 32'(gnt), 32'h8);
    step(); check("rr_q3", 32'(q), 32'h44);
    step(); check("rr_g4", 32'(gnt), 32'h1);
    req = '0;
    step(); check("rr_q4", 32'(q), 32'h11); check("rr_wcnt", 32'(wcnt), 32'h5);

    // Requester 2 drops req during GRANT; the write still commits.
    // Other slices carry junk that must be ignored.
    req   = 4'b0100;
    wdata = {8'hEE, 8'h77, 8'hDD, 8'hCC};
    step(); check("drop_gnt", 32'(gnt), 32'h4);
    req = '0;
    step(); check("drop_q", 32'(q), 32'h77); check("drop_wcnt", 32'(wcnt), 32'h6);

    // Reset mid-GRANT aborts the write immediately.
    req   = 4'b1000;
    wdata = {8'h5A, 8'h00, 8'h00, 8'h00};
    step(); check("abort_gnt_pre", 32'(gnt), 32'h8);
    #2 reset = 1'b0;
    #1;
    check("abort_gnt", 32'(gnt), 32'h0);
    check("abort_q", 32'(q), 32'h0);
    check("abort_wcnt", 32'(wcnt), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    #1 reset = 1'b1;
    step(); check("resume_gnt", 32'(gnt), 32'h8); check("resume_q", 32'(q), 32'h0);
    req = '0;
    step(); check("resume_q2", 32'(q), 32'h5A); check("resume_wcnt", 32'(wcnt), 32'h1);

    // 256 single writes wrap the write counter.
    do_reset();
    wdata = {8'h00, 8'h00, 8'h00, 8'h3C};
    for (int i = 0; i < 256; i++) begin
      req = 4'b0001;
      step();
      check("wrap_gnt", 32'(gnt), 32'h1);
      req = '0;
      step();
      if (i == 254) check("wrap_255", 32'(wcnt), 32'hFF);
    end
    check("wrap_0", 32'(wcnt), 32'h0);
    check("wrap_q", 32'(q), 32'h3C);

`ifdef RFF_ARB_LOCK_EN
    // Locked burst: requester 0 holds for 8 cycles, then requester 1.
    do_reset();
    req   = 4'b0011;
    lock  = 4'b0001;
    wdata = {8'h00, 8'h00, 8'hB2, 8'hB1};
    for (int i = 0; i < 8; i++) begin
      step();
      check("lock_hold", 32'(gnt), 32'h1);
    end
    step();
    check("lock_exit", 32'(gnt), 32'h0);
    check("lock_wcnt", 32'(wcnt), 32'h8);
    check("lock_q", 32'(q), 32'hB1);
    step();
    check("lock_next", 32'(gnt), 32'h2);
    req  = '0;
    lock = '0;
    step();
    check("lock_q2", 32'(q), 32'hB2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
